// File: rtl/chaos_seq_arb.sv
// rtl/chaos_seq_arb.sv - round-robin arbiter sharing one chaos sequence generator
//
// Purpose: NUM_REQ requesters each offer a seed; one is granted round-robin,
// its seed is pushed to the generator, the resulting chaos word (or a timeout
// marker) is returned to that requester only.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_x0/req_vld/req_rdy      per-requester seed handshake (seed i at [i*GAIN_INDEX +: GAIN_INDEX])
//   rsp_data/rsp_err            shared result, rsp_err marks a timeout result
//   rsp_vld/rsp_rdy             per-requester response handshake (one-hot valid)
//   gen_x0/gen_x0_vld/_rdy      seed handshake towards the generator
//   gen_xout/gen_xout_vld/_rdy  chaos word handshake from the generator
//   busy                        high whenever not IDLE
//   grant_id                    current or last granted requester
//   timeout_cnt                 saturating count of generator timeouts
module chaos_seq_arb #(
  parameter int NUM_REQ      = 4,
  parameter int GAIN_INDEX   = 16,
  parameter int CHAOS_OVLD_W = 32,
  parameter int TIMEOUT      = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*GAIN_INDEX-1:0] req_x0,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [CHAOS_OVLD_W-1:0]       rsp_data,
  output logic                          rsp_err,
  output logic [NUM_REQ-1:0]            rsp_vld,
  input  logic [NUM_REQ-1:0]            rsp_rdy,
  output logic [GAIN_INDEX-1:0]         gen_x0,
  output logic                          gen_x0_vld,
  input  logic                          gen_x0_rdy,
  input  logic [CHAOS_OVLD_W-1:0]       gen_xout,
  input  logic                          gen_xout_vld,
  output logic                          gen_xout_rdy,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [7:0]                    timeout_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [ID_W-1:0]       rr_ptr;
  logic [GAIN_INDEX-1:0] seed_q;
  logic [WC_W-1:0]       wait_cnt;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W:0]         cand;
  logic [GAIN_INDEX-1:0] seed_sel;
  logic                  wait_expired;

  assign gen_x0       = seed_q;
  assign busy         = rst_n && (state != IDLE);
  assign wait_expired = (wait_cnt == WC_W'(TIMEOUT - 1));

  // Round-robin search starting at rr_ptr. Iterating from the farthest
  // candidate down to rr_ptr lets the nearest set bit win the last write.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (req_vld[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    seed_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        seed_sel = req_x0[i*GAIN_INDEX +: GAIN_INDEX];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt    = state;
    req_rdy      = '0;
    rsp_vld      = '0;
    gen_x0_vld   = 1'b0;
    gen_xout_rdy = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_rdy[grant_idx] = 1'b1;
          state_nxt          = ISSUE;
        end
      end
      ISSUE: begin
        gen_x0_vld = 1'b1;
        if (gen_x0_rdy) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        gen_xout_rdy = 1'b1;
        if (gen_xout_vld || wait_expired) begin
          state_nxt = RETURN;
        end
      end
      RETURN: begin
        rsp_vld[grant_id] = 1'b1;
        if (rsp_rdy[grant_id]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Handshakes stay quiet while reset is held, even before the first edge.
    if (!rst_n) begin
      req_rdy      = '0;
      rsp_vld      = '0;
      gen_x0_vld   = 1'b0;
      gen_xout_rdy = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      seed_q      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      timeout_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant_id <= grant_idx;
            // Zero is a fixed point of the map and would yield a dead sequence.
            seed_q   <= (seed_sel == '0) ? GAIN_INDEX'(1) : seed_sel;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + WC_W'(1);
          // A result arriving on the timeout cycle still counts as a result.
          if (gen_xout_vld) begin
            rsp_data <= gen_xout;
            rsp_err  <= 1'b0;
          end else if (wait_expired) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
          end
        end
        RETURN: begin
          if (rsp_rdy[grant_id]) begin
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/chaos_seq_arb.md
CHAOS_SEQ_ARB -- requirements
Module: chaos_seq_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters sharing one chaos sequence generator (range 2..16).
REQ-002 SHALL have parameter GAIN_INDEX, default 16, the seed width (fixed-point gain index).
REQ-003 SHALL have parameter CHAOS_OVLD_W, default 32, the width of a generated chaos word.
REQ-004 SHALL have parameter TIMEOUT, default 1024, the maximum cycles allowed in WAIT.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req_x0, input, NUM_REQ*GAIN_INDEX bits: per-requester seeds; requester i occupies slice [i*GAIN_INDEX +: GAIN_INDEX].
REQ-008 SHALL have port req_vld, input, NUM_REQ bits: per-requester seed valid.
REQ-009 SHALL have port req_rdy, output, NUM_REQ bits: per-requester seed ready.
REQ-010 SHALL have port rsp_data, output, CHAOS_OVLD_W bits: result shared by all requesters.
REQ-011 SHALL have port rsp_err, output, 1 bit: qualifies rsp_data as a timeout result.
REQ-012 SHALL have port rsp_vld, output, NUM_REQ bits: per-requester response valid, at most one bit set.
REQ-013 SHALL have port rsp_rdy, input, NUM_REQ bits: per-requester response ready.
REQ-014 SHALL have port gen_x0, output, GAIN_INDEX bits: seed driven to the generator.
REQ-015 SHALL have port gen_x0_vld, output, 1 bit: seed valid to the generator.
REQ-016 SHALL have port gen_x0_rdy, input, 1 bit: seed ready from the generator.
REQ-017 SHALL have port gen_xout, input, CHAOS_OVLD_W bits: chaos word from the generator.
REQ-018 SHALL have port gen_xout_vld, input, 1 bit: chaos word valid from the generator.
REQ-019 SHALL have port gen_xout_rdy, output, 1 bit: chaos word ready to the generator.
REQ-020 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-021 SHALL have port grant_id, output, $clog2(NUM_REQ) bits: index of the current or last grant.
REQ-022 SHALL have port timeout_cnt, output, 8 bits: saturating count of timeouts.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT and RETURN; all handshakes complete on a cycle where vld and rdy are both 1.
REQ-024 IDLE: SHALL grant, when any req_vld bit is set, the first set bit searched from rr_ptr upward with wrap-around (round-robin).
REQ-025 IDLE: SHALL drive req_rdy[g]=1 combinationally in the grant cycle only, and keep req_rdy at 0 in all other states.
REQ-026 IDLE: SHALL latch the granted seed into the seed register and g into grant_id in the grant cycle, then go to ISSUE.
REQ-027 IDLE: SHALL substitute a seed of 0 with 1, because 0 is a fixed point of the map.
REQ-028 ISSUE: SHALL hold gen_x0_vld=1 with gen_x0 stable until gen_x0_rdy=1, then go to WAIT, with no cycle limit in ISSUE.
REQ-029 WAIT: SHALL drive gen_xout_rdy=1 and count cycles in wait_cnt, which is cleared on entry to WAIT.
REQ-030 WAIT: on gen_xout_vld=1, SHALL capture gen_xout into rsp_data, clear rsp_err and go to RETURN.
REQ-031 WAIT: when wait_cnt reaches TIMEOUT-1 with gen_xout_vld=0, SHALL set rsp_data=0 and rsp_err=1, increment timeout_cnt (saturating at 255) and go to RETURN.
REQ-032 WAIT: if gen_xout_vld=1 arrives in the same cycle as the timeout, SHALL treat it as a normal result.
REQ-033 RETURN: SHALL hold rsp_vld[grant_id]=1 with rsp_data and rsp_err stable until rsp_rdy[grant_id]=1.
REQ-034 RETURN: on response accept, SHALL set rr_ptr=(grant_id+1) mod NUM_REQ and go to IDLE; the next grant cannot occur earlier than the following cycle.
REQ-035 SHALL keep gen_xout_rdy=0 outside WAIT, so a late generator result after a timeout is held off by the generator until the next WAIT.
REQ-036 SHALL ignore rsp_rdy bits of non-granted requesters, and req_vld changes outside IDLE.
REQ-037 SHALL have a worst-case wait for a continuously requesting requester of NUM_REQ-1 other complete transactions.

Reset
REQ-038 On rst_n=0 at a rising edge, SHALL set: state=IDLE, rr_ptr=0, grant_id=0, rsp_data=0, rsp_err=0, timeout_cnt=0, wait_cnt=0.
REQ-039 Under reset, SHALL drive req_rdy, rsp_vld, gen_x0_vld, gen_xout_rdy and busy to 0.
REQ-040 A reset asserted mid-transaction SHALL abort it with no response issued; the generator is reset by the same rst_n.

Verification
REQ-041 Single requester: req_vld=4'b0001 with seed 16'h4000; generator answers 32'hA5A5_0001 -> exactly one rsp_vld[0] carrying 32'hA5A5_0001 with rsp_err=0, then rr_ptr=1.
REQ-042 All four requesters hold req_vld=4'b1111 continuously -> grants occur in order 0,1,2,3,0, each with one response to the matching requester.
REQ-043 Zero seed: requester 2 sends seed 0 -> gen_x0=16'h0001 is observed.
REQ-044 Timeout with TIMEOUT=8 and a generator that never asserts gen_xout_vld -> rsp_vld set 8 cycles after WAIT entry, rsp_data=0, rsp_err=1, timeout_cnt=1.
REQ-045 Backpressure: rsp_rdy=0 for 5 cycles in RETURN -> rsp_data stable, no new grant, gen_xout_rdy=0 throughout.
REQ-046 Reset asserted in WAIT -> next cycle has state IDLE, busy=0, rsp_vld=0, rr_ptr=0.
